// File: rtl/neuron_output_stage.sv
// Neuron output stage: bias add, rescale, activation, saturation, output FIFO and layer counting.
// Optional ReLU activation is enabled by defining NEURON_OUT_RELU_EN; otherwise the activation is linear.
module neuron_output_stage #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_valid,
    input  logic [ACC_W-1:0] acc_data,
    input  logic [ACC_W-1:0] bias,
    input  logic [7:0]       layer_size,
    output logic             acc_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             layer_done,
    output logic             overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SUM_W-1:0] s1_sum_reg;
    logic                    s1_valid_reg;
    logic [OUT_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [7:0]              neuron_cnt_reg;
    logic                    layer_done_reg;
    logic                    overflow_reg;

    logic                    capture;
    logic                    push;
    logic                    pop;
    logic                    last_neuron;
    logic [CNT_W:0]          occupancy;
    logic signed [SUM_W-1:0] shifted;
    logic signed [SUM_W-1:0] activated;
    logic [OUT_W-1:0]        result;

    // Occupancy includes the entry in flight so a stage-2 write always finds room.
    assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, s1_valid_reg};
    assign acc_ready = occupancy < (CNT_W+1)'(DEPTH);

    assign capture     = acc_valid && acc_ready;
    assign push        = s1_valid_reg;
    assign out_valid   = (count_reg != '0);
    assign pop         = out_valid && out_ready;
    assign last_neuron = (neuron_cnt_reg == (layer_size - 8'd1));

    assign shifted = s1_sum_reg >>> SHIFT;

    always_comb begin
        activated = shifted;
`ifdef NEURON_OUT_RELU_EN
        if (shifted[SUM_W-1]) begin
            activated = '0;
        end
`endif
        result = activated[OUT_W-1:0];
        if (activated > SAT_MAX) begin
            result = SAT_MAX[OUT_W-1:0];
        end else if (activated < SAT_MIN) begin
            result = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sum_reg   <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= capture;
            if (capture) begin
                s1_sum_reg <= {acc_data[ACC_W-1], acc_data} + {bias[ACC_W-1], bias};
            end
        end
    end

    // Storage carries no reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= result;
        end
    end

    assign out_data = out_valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neuron_cnt_reg <= '0;
            layer_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            layer_done_reg <= push && last_neuron;
            if (push) begin
                neuron_cnt_reg <= last_neuron ? 8'd0 : neuron_cnt_reg + 8'd1;
            end
            if (acc_valid && !acc_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign layer_done = layer_done_reg;
    assign overflow   = overflow_reg;

endmodule

// File: doc/neuron_output_stage.md
# neuron_output_stage

Downstream stage of the neuron MAC controller. It captures each accumulated dot product on the controller's one-cycle `ready` pulse, adds a per-neuron bias, rescales, applies the activation and saturates to the output width. The result is buffered in a small FIFO that feeds the next layer over a valid/ready handshake. It also counts neurons and flags the end of each layer.

## Interface
- `ACC_W`, 32: accumulator and bias width, signed two's complement.
- `OUT_W`, 16: output width, signed.
- `SHIFT`, 8: arithmetic right shift applied after the bias add (fixed-point rescale).
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `acc_valid`  in  1  one-cycle pulse; `acc_data`/`bias` valid this cycle (driven from controller `ready`).
- `acc_data`  in  ACC_W  accumulated sum, signed.
- `bias`  in  ACC_W  bias for this neuron, signed.
- `layer_size`  in  8  neurons per layer; 0 means 256. Sampled on every write.
- `acc_ready`  out  1  space available; upstream may pulse `acc_valid` only while high.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  OUT_W  FIFO head, signed.
- `out_ready`  in  1  consumer accepts head when `out_valid && out_ready`.
- `layer_done`  out  1  one-cycle pulse on the write of the last neuron of a layer.
- `overflow`  out  1  sticky: `acc_valid` arrived while `acc_ready` was low.

## Operation
- Stage 1 runs at the edge where `acc_valid` = 1 and `acc_ready` = 1.
  - `s1_sum <= sext(acc_data) + sext(bias)`, kept at ACC_W+1 bits with no wrap.
  - `s1_valid <= 1`.
- Stage 2 runs on the next edge when `s1_valid` = 1.
  - `r = s1_sum >>> SHIFT`, arithmetic shift, floor rounding.
  - Apply the activation (see Configuration).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Write the result into the FIFO tail; `s1_valid` clears unless a new capture happens on the same edge.
- Back-to-back `acc_valid` pulses are accepted every cycle while space remains.
- Space accounting: `acc_ready = (fifo_count + s1_valid) < DEPTH`. It is combinational and includes the in-flight entry, so a stage-2 write never finds the FIFO full.
- `acc_valid` while `acc_ready` = 0:
  - The input is dropped and `overflow` sets.
  - `overflow` clears only on `rst`.
- FIFO:
  - Circular buffer with wrap-around read and write pointers and a count of width log2(DEPTH)+1.
  - Pop happens on `out_valid && out_ready`.
  - A push and a pop on the same edge leave the count unchanged, including when the FIFO is full or holds one entry.
  - A pop while empty is ignored.
- Neuron counter (8 bit) increments on each FIFO write.
  - When it equals `layer_size - 1` (mod 256) at a write, `layer_done` pulses on the cycle after that write and the counter returns to 0.
- Reset mid-operation clears the pipeline, the FIFO (contents discarded), the counter and `overflow` immediately.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `layer_done` = 0, `overflow` = 0.
  - `acc_ready` = 1 (count 0, `s1_valid` 0).
- Latency: `acc_valid` sampled at edge t → `out_valid` = 1 and `out_data` valid after edge t+1, i.e. 2 cycles with an empty FIFO.
- `out_data` is the registered head, read combinationally from FIFO storage, and stays stable while `out_valid && !out_ready`.
- Throughput: 1 result per cycle. `acc_ready` falls in the same cycle that the admitted occupancy reaches DEPTH.
- `layer_done` is asserted together with the `out_valid` update for that write.

## Configuration
- `NEURON_OUT_RELU_EN` defined: ReLU, so negative `r` becomes 0 before saturation. Output range is [0, 2^(OUT_W-1)-1].
- Undefined: linear (identity) activation; only signed saturation is applied.

## Test plan
- SHIFT=8, `acc_data`=0x00001200, `bias`=0x00000100, `out_ready`=1 → `out_data`=0x0013, `out_valid` high exactly 2 cycles after the pulse.
- `acc_data`=0xFFFFFB00, `bias`=0 → with RELU_EN `out_data`=0x0000; without it `out_data`=0xFFFB (-5).
- `acc_data`=0x7FFFFF00, `bias`=0x00000100 → `out_data`=0x7FFF. With `acc_data`=0x80000000, `bias`=0xFFFFFFFF and no RELU → `out_data`=0x8000.
- `out_ready`=0, DEPTH=4, five pulses one per cycle:
  - First four accepted; `acc_ready`=0 after the fourth.
  - Fifth dropped; `overflow`=1.
  - Then `out_ready`=1 → four results drain in order, `acc_ready` returns to 1, `overflow` stays 1.
- `layer_size`=3, six results → `layer_done` pulses with the 3rd and 6th writes only. Simultaneous push/pop at count 1 keeps `out_valid`=1.
- Assert `rst` with 2 entries buffered and 1 in flight → all outputs take reset values asynchronously and the next accepted input emerges 2 cycles later with the neuron count restarted.
